// File: rtl/cart_loader.sv
// cart_loader: ioctl cart download sequencer (ioctl_* from hps_io, ram_* to cart dpram, cart_*/joy*/size/ready latched for the core)
module cart_loader #(
  parameter logic [7:0] BIOS_INDEX = 8'd0,
  parameter int         HDR_LEN    = 128,
  parameter int         RAM_AW     = 18
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cart_is_7800,
  output logic [15:0]       cart_flags,
  output logic [7:0]        joy0_type,
  output logic [7:0]        joy1_type,
  output logic [7:0]        cart_region,
  output logic [7:0]        cart_save,
  output logic [31:0]       cart_size,
  output logic              cart_ready,
  output logic              busy,
  output logic              overflow
);
  typedef enum logic [2:0] {IDLE, PROBE, REPLAY, HEADER, DATA, FINISH} state_t;
  state_t state, state_n;
  logic cdl, cdl_q, start, stop, stb, probe_hit, is_atari, rp_last, done;
  logic [7:0] pbuf [0:7];
  logic [2:0] pcnt, rp, rn;
  logic [RAM_AW:0] wc;
  assign cdl = ioctl_download & (ioctl_index != BIOS_INDEX);
  assign start = cdl & ~cdl_q;
  assign stop = ~cdl & cdl_q;
  assign stb = ioctl_wr & cdl;
  assign probe_hit = stb & (state == PROBE) & (ioctl_addr == 25'd5);
  assign is_atari = {pbuf[1], pbuf[2], pbuf[3], pbuf[4], ioctl_dout} == "ATARI";
  assign rp_last = rp == rn - 3'd1;
  assign ioctl_wait = (state == REPLAY) | (probe_hit & ~is_atari);
  assign busy = state != IDLE;
  always_ff @(posedge clk_sys) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (start) state_n = PROBE;
    else
      case (state)
        PROBE:   if (probe_hit) state_n = is_atari ? HEADER : REPLAY;
                 else if (stop) state_n = (pcnt == 3'd0) ? FINISH : REPLAY;
        REPLAY:  if (rp_last) state_n = (done | stop) ? FINISH : DATA;
        HEADER:  if (stop) state_n = FINISH;
                 else if (stb && ioctl_addr == 25'(HDR_LEN - 1)) state_n = DATA;
        DATA:    if (stop) state_n = FINISH;
        FINISH:  state_n = IDLE;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cdl_q <= 1'b0;
      pcnt <= '0;
      rp <= '0;
      rn <= '0;
      done <= 1'b0;
      wc <= '0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      cart_is_7800 <= 1'b0;
      cart_flags <= '0;
      joy0_type <= 8'd1;
      joy1_type <= 8'd1;
      cart_region <= '0;
      cart_save <= '0;
      cart_size <= '0;
      cart_ready <= 1'b0;
      overflow <= 1'b0;
    end else begin
      cdl_q <= cdl;
      ram_we <= 1'b0;
      if (start) begin
        cart_is_7800 <= 1'b0;
        cart_flags <= '0;
        joy0_type <= 8'd1;
        joy1_type <= 8'd1;
        cart_region <= '0;
        cart_save <= '0;
        cart_size <= '0;
        overflow <= 1'b0;
        wc <= '0;
        done <= 1'b0;
        pcnt <= {2'b00, stb};
        if (stb) pbuf[ioctl_addr[2:0]] <= ioctl_dout;
      end else
        case (state)
          PROBE: begin
            if (stb) begin
              pbuf[ioctl_addr[2:0]] <= ioctl_dout;
              pcnt <= pcnt + 3'd1;
            end
            if (probe_hit && is_atari) cart_is_7800 <= 1'b1;
            else if (probe_hit) begin
              ram_we <= 1'b1;
              ram_addr <= '0;
              ram_data <= pbuf[0];
              wc <= (RAM_AW+1)'(1);
              rp <= 3'd1;
              rn <= 3'd6;
            end else if (stop) begin
              rp <= '0;
              rn <= pcnt;
              done <= 1'b1;
            end
          end
          REPLAY: begin
            ram_we <= 1'b1;
            ram_addr <= wc[RAM_AW-1:0];
            ram_data <= pbuf[rp];
            wc <= wc + (RAM_AW+1)'(1);
            rp <= rp + 3'd1;
            if (stop) done <= 1'b1;
          end
          HEADER:
            if (stb)
              case (ioctl_addr)
                25'd53:  cart_flags[15:8] <= ioctl_dout;
                25'd54:  cart_flags[7:0] <= ioctl_dout;
                25'd55:  joy0_type <= ioctl_dout;
                25'd56:  joy1_type <= ioctl_dout;
                25'd57:  cart_region <= ioctl_dout;
                25'd58:  cart_save <= ioctl_dout;
                default: ;
              endcase
          DATA:
            if (stb) begin
              if (wc[RAM_AW]) overflow <= 1'b1;
              else begin
                ram_we <= 1'b1;
                ram_addr <= wc[RAM_AW-1:0];
                ram_data <= ioctl_dout;
                wc <= wc + (RAM_AW+1)'(1);
              end
            end
          FINISH: begin
            cart_size <= 32'(wc);
            cart_ready <= 1'b1;
          end
          default: ;
        endcase
    end
  end
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: randomized file downloads checked against a file-level model of the loader
module tb_cart_loader;
  localparam int AW = 14;
  localparam int CAP = 1 << AW;
  localparam int MAXF = CAP + 400;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0;
  logic [7:0] ioctl_index = 8'd1, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = '0;
  logic ioctl_wait, ram_we, cart_is_7800, cart_ready, busy, overflow;
  logic [AW-1:0] ram_addr;
  logic [7:0] ram_data, joy0_type, joy1_type, cart_region, cart_save;
  logic [15:0] cart_flags;
  logic [31:0] cart_size;
  cart_loader #(.BIOS_INDEX(8'd0), .HDR_LEN(128), .RAM_AW(AW)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .cart_is_7800(cart_is_7800),
    .cart_flags(cart_flags), .joy0_type(joy0_type), .joy1_type(joy1_type), .cart_region(cart_region),
    .cart_save(cart_save), .cart_size(cart_size), .cart_ready(cart_ready), .busy(busy), .overflow(overflow)
  );
  always #5 clk_sys = ~clk_sys;
  logic [7:0] fbytes [0:MAXF-1];
  int checks = 0, failures = 0;
  int cyc = 0, wcnt = 0, wbad = 0, wait_cnt = 0, wait_first = -1, a5_cyc = -2;
  logic [AW-1:0] wlast_a = '0, wfirst_a = '0;
  logic [7:0] wfirst_d = '0;
  bit e78, e_ovf;
  int e_hdr = 0, e_size, e_wait;
  logic [15:0] e_flags;
  logic [7:0] e_j0, e_j1, e_reg, e_save;
  // one sample per cycle, just before the rising edge
  always @(negedge clk_sys) begin
    #4;
    cyc++;
    if (ram_we) begin
      if (wcnt == 0) begin
        wfirst_a = ram_addr;
        wfirst_d = ram_data;
      end
      if (wcnt >= CAP || ram_addr !== AW'(wcnt) || ram_data !== fbytes[e_hdr + wcnt]) wbad++;
      wlast_a = ram_addr;
      wcnt++;
    end
    if (ioctl_wait) begin
      if (wait_first < 0) wait_first = cyc;
      wait_cnt++;
    end
    if (ioctl_wr && ioctl_download && ioctl_index != 8'd0 && ioctl_addr == 25'd5) a5_cyc = cyc;
  end
  function automatic logic [7:0] fld(input bit a78, input int len, input int k, input logic [7:0] d);
    return (a78 && len > k) ? fbytes[k] : d;
  endfunction
  task automatic model(input int len);
    int img;
    e78 = len >= 6 && {fbytes[1], fbytes[2], fbytes[3], fbytes[4], fbytes[5]} == 40'h4154415249;
    e_hdr = e78 ? 128 : 0;
    img = len > e_hdr ? len - e_hdr : 0;
    e_size = img > CAP ? CAP : img;
    e_ovf = img > CAP;
    e_flags = {fld(e78, len, 53, 8'd0), fld(e78, len, 54, 8'd0)};
    e_j0 = fld(e78, len, 55, 8'd1);
    e_j1 = fld(e78, len, 56, 8'd1);
    e_reg = fld(e78, len, 57, 8'd0);
    e_save = fld(e78, len, 58, 8'd0);
    e_wait = e78 ? 0 : (len >= 6 ? 6 : len);
  endtask
  task automatic fill(input int len, input bit atari);
    for (int i = 0; i < len; i++) fbytes[i] = 8'($urandom);
    fbytes[1] = 8'h00;
    if (atari) begin
      fbytes[1] = 8'h41;
      fbytes[2] = 8'h54;
      fbytes[3] = 8'h41;
      fbytes[4] = 8'h52;
      fbytes[5] = 8'h49;
    end
  endtask
  task automatic run_file(input int len, input logic [7:0] idx, input int nsend, input bit do_end);
    int g;
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = idx;
    @(negedge clk_sys);
    wcnt = 0;
    wbad = 0;
    wait_cnt = 0;
    wait_first = -1;
    a5_cyc = -2;
    ioctl_download = 1'b1;
    for (int i = 0; i < nsend && i < len; i++) begin
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      if ($urandom_range(0, 7) == 0) @(negedge clk_sys);
      #1;
      g = 0;
      while (ioctl_wait && g < 64) begin
        @(negedge clk_sys);
        #1;
        g++;
      end
      if (ioctl_wait) begin
        checks++;
        failures++;
        $display("FAIL wait_timeout byte=%0d wait=%b required=0", i, ioctl_wait);
      end
      ioctl_addr = 25'(i);
      ioctl_dout = fbytes[i];
      ioctl_wr = 1'b1;
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    if (do_end) begin
      ioctl_download = 1'b0;
      g = 0;
      do begin
        @(negedge clk_sys);
        g++;
      end while (busy && g < 64);
      if (busy) begin
        checks++;
        failures++;
        $display("FAIL finish_timeout busy=%b required=0", busy);
      end
      @(negedge clk_sys);
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (ioctl_wait !== 1'b0) begin failures++; $display("FAIL rst_wait got=%b exp=0", ioctl_wait); end
    checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", ram_we); end
    checks++; if (cart_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", cart_ready); end
    checks++; if (cart_size !== 32'd0) begin failures++; $display("FAIL rst_size got=%0d exp=0", cart_size); end
    checks++; if ({joy0_type, joy1_type} !== 16'h0101) begin failures++; $display("FAIL rst_joy got=%h exp=0101", {joy0_type, joy1_type}); end
    checks++; if ({cart_is_7800, cart_flags, cart_region, cart_save, overflow} !== '0) begin failures++; $display("FAIL rst_fields got=%h exp=0", {cart_is_7800, cart_flags, cart_region, cart_save, overflow}); end
  endtask
  task automatic test_a78;
    int len = 128 + 16384;
    fill(len, 1);
    fbytes[53] = 8'h00;
    fbytes[54] = 8'h02;
    fbytes[57] = 8'h01;
    model(len);
    run_file(len, 8'd1, len, 1);
    checks++; if (cart_is_7800 !== 1'b1) begin failures++; $display("FAIL a78_is7800 got=%b exp=1", cart_is_7800); end
    checks++; if (cart_flags !== 16'h0002) begin failures++; $display("FAIL a78_flags got=%h exp=0002", cart_flags); end
    checks++; if (cart_region !== 8'h01) begin failures++; $display("FAIL a78_region got=%h exp=01", cart_region); end
    checks++; if ({joy0_type, joy1_type, cart_save} !== {e_j0, e_j1, e_save}) begin failures++; $display("FAIL a78_joy_save got=%h exp=%h", {joy0_type, joy1_type, cart_save}, {e_j0, e_j1, e_save}); end
    checks++; if (wfirst_a !== '0 || wfirst_d !== fbytes[128]) begin failures++; $display("FAIL a78_first_write got=%h/%h exp=0/%h", wfirst_a, wfirst_d, fbytes[128]); end
    checks++; if (wcnt != 16384 || wbad != 0) begin failures++; $display("FAIL a78_writes got=%0d bad=%0d exp=16384 bad=0", wcnt, wbad); end
    checks++; if (cart_size !== 32'd16384) begin failures++; $display("FAIL a78_size got=%0d exp=16384", cart_size); end
    checks++; if (cart_ready !== 1'b1) begin failures++; $display("FAIL a78_ready got=%b exp=1", cart_ready); end
    checks++; if (wait_cnt != 0) begin failures++; $display("FAIL a78_wait got=%0d exp=0", wait_cnt); end
  endtask
  task automatic test_raw;
    fill(4096, 0);
    model(4096);
    run_file(4096, 8'd1, 4096, 1);
    checks++; if (wait_cnt != 6) begin failures++; $display("FAIL raw_wait_cycles got=%0d exp=6", wait_cnt); end
    checks++; if (wait_first != a5_cyc) begin failures++; $display("FAIL raw_wait_start got=%0d exp=%0d", wait_first, a5_cyc); end
    checks++; if (wcnt != 4096 || wbad != 0) begin failures++; $display("FAIL raw_writes got=%0d bad=%0d exp=4096 bad=0", wcnt, wbad); end
    checks++; if (cart_size !== 32'd4096) begin failures++; $display("FAIL raw_size got=%0d exp=4096", cart_size); end
    checks++; if ({cart_is_7800, joy0_type, joy1_type, overflow} !== {1'b0, 8'd1, 8'd1, 1'b0}) begin failures++; $display("FAIL raw_fields got=%h exp=%h", {cart_is_7800, joy0_type, joy1_type, overflow}, {1'b0, 8'd1, 8'd1, 1'b0}); end
  endtask
  task automatic test_short;
    fill(3, 0);
    model(3);
    run_file(3, 8'd1, 3, 1);
    checks++; if (wcnt != 3 || wbad != 0) begin failures++; $display("FAIL short_writes got=%0d bad=%0d exp=3 bad=0", wcnt, wbad); end
    checks++; if (cart_size !== 32'd3) begin failures++; $display("FAIL short_size got=%0d exp=3", cart_size); end
    checks++; if (wait_cnt != 3) begin failures++; $display("FAIL short_wait got=%0d exp=3", wait_cnt); end
    model(0);
    run_file(0, 8'd1, 0, 1);
    checks++; if (wcnt != 0) begin failures++; $display("FAIL empty_writes got=%0d exp=0", wcnt); end
    checks++; if (cart_size !== 32'd0 || cart_ready !== 1'b1) begin failures++; $display("FAIL empty_size_ready got=%0d/%b exp=0/1", cart_size, cart_ready); end
  endtask
  task automatic test_overflow;
    int len = CAP + 200;
    fill(len, 0);
    model(len);
    run_file(len, 8'd1, len, 1);
    checks++; if (wlast_a !== AW'(CAP - 1)) begin failures++; $display("FAIL ovf_last_addr got=%h exp=%h", wlast_a, AW'(CAP - 1)); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (cart_size !== 32'(CAP)) begin failures++; $display("FAIL ovf_size got=%0d exp=%0d", cart_size, CAP); end
    checks++; if (wcnt != CAP || wbad != 0) begin failures++; $display("FAIL ovf_writes got=%0d bad=%0d exp=%0d bad=0", wcnt, wbad, CAP); end
  endtask
  task automatic test_bios;
    for (int i = 0; i < 4096; i++) fbytes[i] = 8'($urandom);
    run_file(4096, 8'd0, 4096, 1);
    checks++; if (wcnt != 0 || wait_cnt != 0) begin failures++; $display("FAIL bios_activity got=%0d/%0d exp=0/0", wcnt, wait_cnt); end
    checks++; if (cart_size !== 32'(e_size) || overflow !== e_ovf || cart_is_7800 !== e78) begin failures++; $display("FAIL bios_outputs got=%0d/%b/%b exp=%0d/%b/%b", cart_size, overflow, cart_is_7800, e_size, e_ovf, e78); end
    checks++; if (cart_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL bios_ready_busy got=%b/%b exp=1/0", cart_ready, busy); end
  endtask
  task automatic test_back_to_back;
    fill(3000, 0);
    model(3000);
    run_file(3000, 8'd1, 1000, 0);
    fill(2000, 0);
    model(2000);
    run_file(2000, 8'd1, 2000, 1);
    checks++; if (cart_size !== 32'd2000) begin failures++; $display("FAIL b2b_size got=%0d exp=2000", cart_size); end
    checks++; if (wcnt != 2000 || wbad != 0) begin failures++; $display("FAIL b2b_writes got=%0d bad=%0d exp=2000 bad=0", wcnt, wbad); end
    checks++; if (wait_cnt != 6 || overflow !== 1'b0) begin failures++; $display("FAIL b2b_wait_ovf got=%0d/%b exp=6/0", wait_cnt, overflow); end
  endtask
  task automatic test_reset_mid;
    int len = 128 + 700;
    fill(100, 0);
    model(100);
    run_file(100, 8'd1, 6, 0);
    #1;
    checks++; if (ioctl_wait !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL mid_in_replay got=%b/%b exp=1/1", ioctl_wait, busy); end
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    #1;
    checks++; if (ioctl_wait !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_after_reset got=%b/%b/%b exp=0/0/0", ioctl_wait, ram_we, busy); end
    checks++; if (cart_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_cleared got=%b exp=0", cart_ready); end
    fill(len, 1);
    model(len);
    run_file(len, 8'd3, len, 1);
    checks++; if (cart_ready !== 1'b1 || cart_size !== 32'd700) begin failures++; $display("FAIL mid_reload got=%b/%0d exp=1/700", cart_ready, cart_size); end
    checks++; if (wcnt != 700 || wbad != 0 || cart_is_7800 !== 1'b1) begin failures++; $display("FAIL mid_reload_writes got=%0d bad=%0d is7800=%b exp=700 bad=0 is7800=1", wcnt, wbad, cart_is_7800); end
  endtask
  task automatic test_random;
    int len;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 400);
      fill(len, $urandom_range(0, 1) == 1);
      model(len);
      run_file(len, 8'($urandom_range(1, 255)), len, 1);
      checks++; if (cart_size !== 32'(e_size)) begin failures++; $display("FAIL rnd%0d_size len=%0d got=%0d exp=%0d", t, len, cart_size, e_size); end
      checks++; if (wcnt != e_size || wbad != 0) begin failures++; $display("FAIL rnd%0d_writes got=%0d bad=%0d exp=%0d bad=0", t, wcnt, wbad, e_size); end
      checks++; if (cart_is_7800 !== e78 || overflow !== e_ovf) begin failures++; $display("FAIL rnd%0d_is7800_ovf got=%b/%b exp=%b/%b", t, cart_is_7800, overflow, e78, e_ovf); end
      checks++; if (cart_flags !== e_flags) begin failures++; $display("FAIL rnd%0d_flags got=%h exp=%h", t, cart_flags, e_flags); end
      checks++; if ({joy0_type, joy1_type, cart_region, cart_save} !== {e_j0, e_j1, e_reg, e_save}) begin failures++; $display("FAIL rnd%0d_fields got=%h exp=%h", t, {joy0_type, joy1_type, cart_region, cart_save}, {e_j0, e_j1, e_reg, e_save}); end
      checks++; if (wait_cnt != e_wait) begin failures++; $display("FAIL rnd%0d_wait got=%0d exp=%0d", t, wait_cnt, e_wait); end
      checks++; if (cart_ready !== 1'b1) begin failures++; $display("FAIL rnd%0d_ready got=%b exp=1", t, cart_ready); end
    end
  endtask
  initial begin
    test_reset;
    test_a78;
    test_raw;
    test_short;
    test_overflow;
    test_bios;
    test_back_to_back;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
